// File: rtl/div_32_11_rebuild.sv
// div_32_11_rebuild: rebuilds X = 11*Q + R through a 2-stage valid/ready pipeline; DIV11_RANGE_CHK_EN enables rem_err/ovf
module div_32_11_rebuild #(
  parameter int QW      = 29,
  parameter int RW      = 4,
  parameter int XW      = 32,
  parameter int DIVISOR = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] Q_in,
  input  logic [RW-1:0] R_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] X_out,
  output logic          rem_err,
  output logic          ovf
);
`ifdef DIV11_RANGE_CHK_EN
  localparam int PW = XW + 1;
`else
  localparam int PW = XW;
`endif
  if (DIVISOR != 11) begin : g_divisor_fixed_at_11
  end
  logic          r_s1_valid;
  logic [QW-1:0] r_s1_q;
  logic [RW-1:0] r_s1_r;
  logic [PW-1:0] r_s1_p;
  logic          r_s2_valid;
  logic [XW-1:0] r_x;
  logic [PW-1:0] w_q_ext;
  logic [PW-1:0] w_x;
  logic          w_s2_adv;
  logic          w_s1_adv;
  assign w_s2_adv  = !r_s2_valid | out_ready;
  assign w_s1_adv  = !r_s1_valid | w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign X_out     = r_x;
  assign w_q_ext   = PW'(Q_in);
  assign w_x       = r_s1_p + PW'(r_s1_q) + PW'(r_s1_r);
  // Stage 1: capture Q, R and the partial product 10*Q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_q     <= '0;
      r_s1_r     <= '0;
      r_s1_p     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_q <= Q_in;
        r_s1_r <= R_in;
        r_s1_p <= (w_q_ext << 3) + (w_q_ext << 1);
      end
    end
  // Stage 2: finish the sum into the output registers, holding while stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_x        <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_x <= w_x[XW-1:0];
    end
`ifdef DIV11_RANGE_CHK_EN
  logic r_ovf;
  logic r_rem;
  assign ovf     = r_ovf;
  assign rem_err = r_rem;
  // Range flags travel with their result through stage 2
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_rem <= 1'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_ovf <= w_x[XW];
      r_rem <= r_s1_r >= RW'(DIVISOR);
    end
`else
  assign ovf     = 1'b0;
  assign rem_err = 1'b0;
`endif
endmodule

// File: tb/tb_div_32_11_rebuild.sv
// tb_div_32_11_rebuild: directed and streaming checks of the 11*Q+R rebuild pipeline
module tb_div_32_11_rebuild;
`ifdef DIV11_RANGE_CHK_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [28:0] Q_in = '0;
  logic [3:0]  R_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] X_out;
  logic        rem_err;
  logic        ovf;
  int errors = 0;
  int checks = 0;
  div_32_11_rebuild dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Q_in(Q_in), .R_in(R_in), .out_valid(out_valid), .out_ready(out_ready),
    .X_out(X_out), .rem_err(rem_err), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [28:0] qs[$];
  logic [3:0]  rs[$];
  logic [28:0] qe;
  logic [3:0]  re;
  int sent, rcvd, cyc;
  bit acc;
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x", X_out, 32'd0);
    chk("rst_flags", {30'd0, rem_err, ovf}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    // basic latency: 11*10+3
    in_valid = 1'b1; Q_in = 29'd10; R_in = 4'd3;
    step();
    in_valid = 1'b0;
    #1 chk("t1_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_x", X_out, 32'h00000071);
    chk("t1_flags", {30'd0, rem_err, ovf}, 32'd0);
    // 32-bit boundary, back-to-back
    in_valid = 1'b1; Q_in = 29'd390451572; R_in = 4'd3;
    step();
    R_in = 4'd4;
    step();
    in_valid = 1'b0;
    chk("t2_max_x", X_out, 32'hFFFFFFFF);
    chk("t2_max_ovf", 32'(ovf), 32'd0);
    step();
    chk("t2_wrap_valid", 32'(out_valid), 32'd1);
    chk("t2_wrap_x", X_out, 32'h00000000);
    chk("t2_wrap_ovf", 32'(ovf), 32'(FLAGS_ON));
    // out-of-range remainder still delivered
    in_valid = 1'b1; Q_in = 29'd5; R_in = 4'd11;
    step();
    in_valid = 1'b0;
    step();
    chk("t3_x", X_out, 32'd66);
    chk("t3_rem_err", 32'(rem_err), 32'(FLAGS_ON));
    chk("t3_ovf", 32'(ovf), 32'd0);
    step();
    chk("t3_drained", 32'(out_valid), 32'd0);
    // stall with capacity 2, then release
    out_ready = 1'b0;
    in_valid = 1'b1; Q_in = 29'd1; R_in = 4'd0;
    step();
    Q_in = 29'd2; R_in = 4'd1;
    #1 chk("t4_ready_s1_full", 32'(in_ready), 32'd1);
    step();
    Q_in = 29'd3; R_in = 4'd2;
    #1 chk("t4_ready_full", 32'(in_ready), 32'd0);
    chk("t4_first_x", X_out, 32'd11);
    step();
    chk("t4_held_ready", 32'(in_ready), 32'd0);
    chk("t4_held_valid", 32'(out_valid), 32'd1);
    chk("t4_held_x", X_out, 32'd11);
    out_ready = 1'b1;
    #1 chk("t4_ready_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_second_x", X_out, 32'd23);
    step();
    chk("t4_third_valid", 32'(out_valid), 32'd1);
    chk("t4_third_x", X_out, 32'd35);
    step();
    chk("t4_drained", 32'(out_valid), 32'd0);
    // random streaming with random backpressure and round-trip division
    sent = 0; rcvd = 0; cyc = 0; acc = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 0;
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        Q_in = 29'($urandom_range(0, 390451572));
        R_in = 4'($urandom_range(0, 10));
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        if (qs.size() == 0) chk("t5_extra_output", 32'd1, 32'd0);
        else begin
          qe = qs.pop_front();
          re = rs.pop_front();
          chk("t5_x", X_out, 32'd11 * {3'd0, qe} + {28'd0, re});
          chk("t5_div_q", X_out / 32'd11, {3'd0, qe});
          chk("t5_div_r", X_out % 32'd11, {28'd0, re});
          chk("t5_flags", {30'd0, rem_err, ovf}, 32'd0);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        qs.push_back(Q_in);
        rs.push_back(R_in);
        sent++;
        acc = 1;
      end
    end
    in_valid = 1'b0;
    chk("t5_received", 32'(rcvd), 32'd1000);
    chk("t5_queue_empty", 32'(qs.size()), 32'd0);
    step();
    out_ready = 1'b1;
    step();
    step();
    chk("t5_idle", 32'(out_valid), 32'd0);
    // reset with two entries in flight
    out_ready = 1'b0;
    in_valid = 1'b1; Q_in = 29'd7; R_in = 4'd1;
    step();
    Q_in = 29'd8;
    step();
    in_valid = 1'b0;
    chk("t6_loaded_x", X_out, 32'd78);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_x", X_out, 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stale", 32'(out_valid), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
